// File: rtl/vadd_sat_elastic.sv
// Vector add/sub/min/max lane with RVV fixed-point saturation behind a two-entry
// valid/ready elastic pipeline (S0 operand register, OUT result register), plus a sticky vxsat flag.

package vadd_sat_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SADD = 3'd2,
    OP_SSUB = 3'd3,
    OP_MIN  = 3'd4,
    OP_MAX  = 3'd5
  } op_e;
endpackage

// One element of width EW; the result is unmasked (the caller applies byte enables).
module vadd_sat_lane
  import vadd_sat_pkg::*;
#(
  parameter int EW = 8
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic [2:0]    op,
  input  logic          sgn,
  output logic [EW-1:0] res,
  output logic          sat
);

  logic [EW:0]   ax, bx, sum, diff;
  logic [EW-1:0] max_pos, min_neg;

  // NOTE: every output of a combinational block gets a default before the case, otherwise unlisted ops infer latches.
  always_comb begin
    ax      = {sgn & a[EW-1], a};
    bx      = {sgn & b[EW-1], b};
    sum     = ax + bx;
    diff    = ax - bx;
    max_pos = {1'b0, {(EW-1){1'b1}}};
    min_neg = {1'b1, {(EW-1){1'b0}}};
    res     = '0;
    sat     = 1'b0;
    // With one guard bit the true result always fits, so diff[EW] is "a < b" for both signednesses.
    case (op)
      OP_ADD: res = sum[EW-1:0];
      OP_SUB: res = diff[EW-1:0];
      OP_SADD: begin
        if (sgn) begin
          if (sum[EW] != sum[EW-1]) begin
            sat = 1'b1;
            res = sum[EW] ? min_neg : max_pos;
          end else begin
            res = sum[EW-1:0];
          end
        end else if (sum[EW]) begin
          sat = 1'b1;
          res = '1;
        end else begin
          res = sum[EW-1:0];
        end
      end
      OP_SSUB: begin
        if (sgn) begin
          if (diff[EW] != diff[EW-1]) begin
            sat = 1'b1;
            res = diff[EW] ? min_neg : max_pos;
          end else begin
            res = diff[EW-1:0];
          end
        end else if (diff[EW]) begin
          sat = 1'b1;
          res = '0;
        end else begin
          res = diff[EW-1:0];
        end
      end
      OP_MIN:  res = diff[EW] ? a : b;
      OP_MAX:  res = diff[EW] ? b : a;
      default: res = '0;
    endcase
  end

endmodule

module vadd_sat_elastic
  import vadd_sat_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int ENABLE_64_BIT = 0,
  parameter int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [1:0]            in_sew,
  input  logic [2:0]            in_op,
  input  logic                  in_signed,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_vxsat_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_sat,
  output logic                  out_vxsat
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] vec0;
    logic [DATA_WIDTH-1:0] vec1;
    logic [1:0]            sew;
    logic [2:0]            op;
    logic                  sgn;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
  } s0_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] vec;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sat;
  } out_t;

  s0_t  s0_q, s0_d;
  out_t out_q, out_d, comp;
  logic s0_valid_q, s0_valid_d;
  logic out_valid_q, out_valid_d;
  logic vxsat_q, vxsat_d;
  logic adv_out, accept, move, supported;

  // Per-SEW result and saturation vectors; sat_w[w] has one bit per element, zero-padded.
  logic [3:0][DATA_WIDTH-1:0] res_w;
  logic [3:0][BE_WIDTH-1:0]   sat_w;

  for (genvar w = 0; w < 4; w++) begin : g_w
    localparam int EW = 8 << w;
    localparam int NE = DATA_WIDTH / EW;
    if (w == 3 && ENABLE_64_BIT == 0) begin : g_off
      assign res_w[w] = '0;
      assign sat_w[w] = '0;
    end else begin : g_on
      for (genvar i = 0; i < NE; i++) begin : g_e
        logic [EW-1:0] r;
        logic          s;
        vadd_sat_lane #(.EW(EW)) u_lane (
          .a  (s0_q.vec0[i*EW +: EW]),
          .b  (s0_q.vec1[i*EW +: EW]),
          .op (s0_q.op),
          .sgn(s0_q.sgn),
          .res(r),
          .sat(s)
        );
        assign res_w[w][i*EW +: EW] = s0_q.be[i*EW/8] ? r : '0;
        assign sat_w[w][i]          = s0_q.be[i*EW/8] & s;
      end
      if (NE < BE_WIDTH) begin : g_pad
        assign sat_w[w][BE_WIDTH-1:NE] = '0;
      end
    end
  end

  always_comb begin
    supported = (s0_q.op <= 3'(OP_MAX)) && !(s0_q.sew == 2'b11 && ENABLE_64_BIT == 0);
    comp.vec  = supported ? res_w[s0_q.sew] : '0;
    comp.sat  = supported & (|sat_w[s0_q.sew]);
    comp.be   = s0_q.be;
    comp.addr = s0_q.addr;
  end

  always_comb begin
    adv_out  = ~out_valid_q | out_ready;
    in_ready = ~s0_valid_q | adv_out;
    accept   = in_valid & in_ready;
    move     = s0_valid_q & adv_out;

    s0_valid_d  = accept | (s0_valid_q & ~adv_out);
    out_valid_d = move | (out_valid_q & ~out_ready);

    s0_d  = s0_q;
    out_d = out_q;
    if (accept) begin
      s0_d = '{vec0: in_vec0, vec1: in_vec1, sew: in_sew, op: in_op,
               sgn: in_signed, be: in_be, addr: in_addr};
    end
    if (move) out_d = comp;

    // Only a fresh load can set the flag, and it overrides a same-edge clear.
    vxsat_d = vxsat_q;
    if (in_vxsat_clr)      vxsat_d = 1'b0;
    if (move && comp.sat)  vxsat_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, because a zeroed output bus after reset is part of the interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vxsat_q     <= 1'b0;
      s0_q        <= '0;
      out_q       <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      out_valid_q <= out_valid_d;
      vxsat_q     <= vxsat_d;
      s0_q        <= s0_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_q.vec;
  assign out_be    = out_q.be;
  assign out_addr  = out_q.addr;
  assign out_sat   = out_q.sat;
  assign out_vxsat = vxsat_q;

endmodule

// File: tb/tb_vadd_sat_elastic.sv
// Directed bench for vadd_sat_elastic: arithmetic vectors, backpressure ordering,
// vxsat set/clear priority and asynchronous reset while beats are in flight.

module tb_vadd_sat_elastic;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_vec0 = '0;
  logic [DW-1:0] in_vec1 = '0;
  logic [1:0]    in_sew = '0;
  logic [2:0]    in_op = '0;
  logic          in_signed = 1'b0;
  logic [BW-1:0] in_be = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_vxsat_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_vec;
  logic [BW-1:0] out_be;
  logic [AW-1:0] out_addr;
  logic          out_sat;
  logic          out_vxsat;

  int total = 0;
  int bad   = 0;

  vadd_sat_elastic #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ENABLE_64_BIT(0), .BE_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_op(in_op),
    .in_signed(in_signed), .in_be(in_be), .in_addr(in_addr),
    .in_vxsat_clr(in_vxsat_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_be(out_be), .out_addr(out_addr),
    .out_sat(out_sat), .out_vxsat(out_vxsat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] sew,
                       input logic [2:0] op, input logic sgn, input logic [BW-1:0] be,
                       input logic [AW-1:0] addr);
    in_vec0   = a;
    in_vec1   = b;
    in_sew    = sew;
    in_op     = op;
    in_signed = sgn;
    in_be     = be;
    in_addr   = addr;
    in_valid  = 1'b1;
  endtask

  // Accept one beat and check it one edge later in OUT (out_ready held high).
  task automatic single(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] sew, input logic [2:0] op, input logic sgn,
                        input logic [BW-1:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] exp_vec, input logic exp_sat);
    drive(a, b, sew, op, sgn, be, addr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " vec"},   out_vec, exp_vec);
    check({tag, " sat"},   64'(out_sat), 64'(exp_sat));
    check({tag, " be"},    64'(out_be), 64'(be));
    check({tag, " addr"},  64'(out_addr), 64'(addr));
  endtask

  task automatic clear_vxsat();
    in_vxsat_clr = 1'b1;
    @(posedge clk); #1;
    in_vxsat_clr = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held low
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_vxsat", 64'(out_vxsat), 64'd0);
    check("rst out_vec",   out_vec, 64'd0);
    check("rst out_be",    64'(out_be), 64'd0);
    check("rst out_addr",  64'(out_addr), 64'd0);
    check("rst out_sat",   64'(out_sat), 64'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // SEW=8 signed sadd: lane0 0x7F+0x01 saturates, others 1+1
    single("s8 sadd", 64'h0101_0101_0101_017F, 64'h0101_0101_0101_0101, 2'b00, 3'd2, 1'b1,
           8'hFF, 32'h0000_0010, 64'h0202_0202_0202_027F, 1'b1);
    @(posedge clk); #1;
    check("s8 sadd vxsat", 64'(out_vxsat), 64'd1);
    check("s8 sadd drained", 64'(out_valid), 64'd0);
    clear_vxsat();
    check("vxsat cleared", 64'(out_vxsat), 64'd0);

    // SEW=8 unsigned saturate / wrap
    single("u8 sadd", 64'hF0F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 2'b00, 3'd2, 1'b0,
           8'hFF, 32'h0000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    single("u8 ssub", 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020, 2'b00, 3'd3, 1'b0,
           8'hFF, 32'h0000_0012, 64'h0000_0000_0000_0000, 1'b1);
    single("u8 add", 64'hF0F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 2'b00, 3'd0, 1'b0,
           8'hFF, 32'h0000_0013, 64'h1010_1010_1010_1010, 1'b0);
    // Lane 7 would saturate but is inactive
    single("u8 inactive", 64'hF000_0000_0000_0010, 64'h2000_0000_0000_0020, 2'b00, 3'd2, 1'b0,
           8'h7F, 32'h0000_0014, 64'h0000_0000_0000_0030, 1'b0);

    // SEW=16 signed ssub and min signed/unsigned
    single("s16 ssub", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 2'b01, 3'd3, 1'b1,
           8'hFF, 32'h0000_0020, 64'h0000_0000_0000_8000, 1'b1);
    single("s16 min", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 2'b01, 3'd4, 1'b1,
           8'hFD, 32'h0000_0021, 64'h0000_0000_0000_8000, 1'b0);
    single("u16 min", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 2'b01, 3'd4, 1'b0,
           8'hFF, 32'h0000_0022, 64'h0000_0000_0000_0001, 1'b0);
    single("u16 max", 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 2'b01, 3'd5, 1'b0,
           8'hFF, 32'h0000_0023, 64'h0000_0000_0000_8000, 1'b0);

    // SEW=32 signed sadd: negative overflow in lane0, positive in lane1
    single("s32 sadd", 64'h7FFF_FFFF_8000_0000, 64'h0000_0001_FFFF_FFFF, 2'b10, 3'd2, 1'b1,
           8'hFF, 32'h0000_0030, 64'h7FFF_FFFF_8000_0000, 1'b1);
    single("u32 sub", 64'h0000_0005_0000_0001, 64'h0000_0003_0000_0002, 2'b10, 3'd1, 1'b0,
           8'hFF, 32'h0000_0031, 64'h0000_0002_FFFF_FFFF, 1'b0);

    // Unsupported encodings flow with be/addr but zero data
    single("sew64 off", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 2'b11, 3'd2, 1'b0,
           8'hA5, 32'hDEAD_0040, 64'h0, 1'b0);
    single("op6 rsvd", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 2'b00, 3'd6, 1'b0,
           8'h3C, 32'hBEEF_0041, 64'h0, 1'b0);
    @(posedge clk); #1;

    // Backpressure: A and B fill the pipe, C waits
    out_ready = 1'b0;
    drive(64'h0000_0000_0000_00AA, 64'h0101_0101_0101_0101, 2'b00, 3'd0, 1'b0, 8'hFF, 32'd1);
    #1;
    check("bp ready A", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(64'h0000_0000_0000_00BB, 64'h0101_0101_0101_0101, 2'b00, 3'd0, 1'b0, 8'hFF, 32'd2);
    check("bp ready B", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(64'h0000_0000_0000_00CC, 64'h0101_0101_0101_0101, 2'b00, 3'd0, 1'b0, 8'hFF, 32'd3);
    check("bp ready C", 64'(in_ready), 64'd0);
    check("bp valid A", 64'(out_valid), 64'd1);
    check("bp vec A",   out_vec, 64'h0101_0101_0101_01AB);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp stall ready", 64'(in_ready), 64'd0);
      check("bp stall vec",   out_vec, 64'h0101_0101_0101_01AB);
      check("bp stall addr",  64'(out_addr), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp ready release", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp valid B", 64'(out_valid), 64'd1);
    check("bp vec B",   out_vec, 64'h0101_0101_0101_01BC);
    check("bp addr B",  64'(out_addr), 64'd2);
    @(posedge clk); #1;
    check("bp valid C", 64'(out_valid), 64'd1);
    check("bp vec C",   out_vec, 64'h0101_0101_0101_01CD);
    check("bp addr C",  64'(out_addr), 64'd3);
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'd0);

    // vxsat: set wins over a clear on the load edge; clear on the next idle edge
    clear_vxsat();
    check("prio pre", 64'(out_vxsat), 64'd0);
    drive(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 2'b00, 3'd2, 1'b0, 8'h01, 32'd7);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_vxsat_clr = 1'b1;
    @(posedge clk); #1;
    check("prio vxsat", 64'(out_vxsat), 64'd1);
    check("prio sat",   64'(out_sat), 64'd1);
    check("prio vec",   out_vec, 64'h0000_0000_0000_00FF);
    @(posedge clk); #1;
    in_vxsat_clr = 1'b0;
    check("prio clear", 64'(out_vxsat), 64'd0);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    drive(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 2'b00, 3'd2, 1'b0, 8'h01, 32'd8);
    @(posedge clk); #1;
    drive(64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022, 2'b00, 3'd0, 1'b0, 8'h01, 32'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid valid", 64'(out_valid), 64'd1);
    check("mid vxsat", 64'(out_vxsat), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst out_vxsat", 64'(out_vxsat), 64'd0);
    check("arst out_vec",   out_vec, 64'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post rst no beat", 64'(out_valid), 64'd0);
    end
    check("post rst ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
